// File: rtl/tt_flit_receiver.sv
// Receive-side depacketizer: parses header / optional timestamp / payload / tail flits,
// delivers port id and payload words, flags framing errors. Optional feature: TT_RX_TIMESTAMP_EN.
module tt_flit_receiver #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  parameter int MAX_MSGLEN      = 1023
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [FLIT_WIDTH-1:0]      flit_sink,
  input  logic                       valid_sink,
  output logic                       ready_sink,
  input  logic                       core_stall,
  input  logic [63:0]                GTB,
  output logic                       portid_valid,
  output logic [7:0]                 sink_portid,
  output logic                       write_en,
  output logic [FLIT_DATA_WIDTH-1:0] sink_dataout,
  output logic                       sink_terminate,
  output logic [31:0]                latency,
  output logic                       latency_valid,
  output logic                       len_err,
  output logic                       proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TS_HI,
    S_TS_LO,
    S_PAYLOAD
  } state_t;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [9:0] COUNT_MAX = 10'(MAX_MSGLEN);

`ifdef TT_RX_TIMESTAMP_EN
  localparam state_t HDR_NEXT = S_TS_HI;
`else
  localparam state_t HDR_NEXT = S_PAYLOAD;
`endif

  state_t                     state_q, state_d;
  logic [9:0]                 count_q, count_d, count_inc;
  logic [9:0]                 msglen_q, msglen_d;
  logic [7:0]                 portid_d;
  logic [FLIT_DATA_WIDTH-1:0] data_d;
  logic                       pv_d, we_d, term_d, len_d, proto_d;

  logic                       accept;
  logic [FLIT_TYPE_WIDTH-1:0] flit_type;
  logic [FLIT_DATA_WIDTH-1:0] flit_data;

`ifdef TT_RX_TIMESTAMP_EN
  logic [31:0] ts_hi_q, ts_hi_d, ts_lo_q, ts_lo_d;
  logic [31:0] lat_q, lat_d;
  logic        latv_q, latv_d;
  logic        unused_bits;
  assign unused_bits   = ^{GTB[63:32], ts_hi_q};
  assign latency       = lat_q;
  assign latency_valid = latv_q;
`else
  logic unused_bits;
  assign unused_bits   = ^GTB;
  assign latency       = 32'd0;
  assign latency_valid = 1'b0;
`endif

  // ready is purely combinational: no skid buffer, stall blocks acceptance in the same cycle
  assign ready_sink = reset_n & ~core_stall;
  assign accept     = valid_sink & ready_sink;
  assign flit_type  = flit_sink[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
  assign flit_data  = flit_sink[FLIT_DATA_WIDTH-1:0];
  assign count_inc  = (count_q == COUNT_MAX) ? count_q : count_q + 10'd1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    msglen_d = msglen_q;
    portid_d = sink_portid;
    data_d   = sink_dataout;
    pv_d     = 1'b0;
    we_d     = 1'b0;
    term_d   = 1'b0;
    len_d    = 1'b0;
    proto_d  = 1'b0;
`ifdef TT_RX_TIMESTAMP_EN
    ts_hi_d  = ts_hi_q;
    ts_lo_d  = ts_lo_q;
    lat_d    = lat_q;
    latv_d   = 1'b0;
`endif

    if (accept) begin
      // a header always restarts parsing; outside IDLE it also aborts the open packet
      if (flit_type == T_HEAD) begin
        portid_d = flit_data[7:0];
        msglen_d = flit_data[17:8];
        count_d  = 10'd0;
        pv_d     = 1'b1;
        proto_d  = (state_q != S_IDLE);
        state_d  = HDR_NEXT;
      end else begin
        case (state_q)
`ifdef TT_RX_TIMESTAMP_EN
          S_TS_HI: begin
            if (flit_type == T_BODY) begin
              ts_hi_d = flit_data[31:0];
              state_d = S_TS_LO;
            end else begin
              proto_d = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_TS_LO: begin
            if (flit_type == T_BODY) begin
              ts_lo_d = flit_data[31:0];
              state_d = S_PAYLOAD;
            end else begin
              proto_d = 1'b1;
              state_d = S_IDLE;
            end
          end
`endif
          S_PAYLOAD: begin
            if (flit_type == T_BODY) begin
              we_d    = 1'b1;
              data_d  = flit_data;
              count_d = count_inc;
            end else if (flit_type == T_TAIL) begin
              we_d    = 1'b1;
              data_d  = flit_data;
              term_d  = 1'b1;
              len_d   = (count_inc != msglen_q);
              count_d = 10'd0;
              state_d = S_IDLE;
`ifdef TT_RX_TIMESTAMP_EN
              lat_d   = GTB[31:0] - ts_lo_q;
              latv_d  = 1'b1;
`endif
            end else begin
              proto_d = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: begin
            proto_d = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      count_q        <= 10'd0;
      msglen_q       <= 10'd0;
      sink_portid    <= 8'd0;
      sink_dataout   <= '0;
      portid_valid   <= 1'b0;
      write_en       <= 1'b0;
      sink_terminate <= 1'b0;
      len_err        <= 1'b0;
      proto_err      <= 1'b0;
`ifdef TT_RX_TIMESTAMP_EN
      ts_hi_q        <= 32'd0;
      ts_lo_q        <= 32'd0;
      lat_q          <= 32'd0;
      latv_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      msglen_q       <= msglen_d;
      sink_portid    <= portid_d;
      sink_dataout   <= data_d;
      portid_valid   <= pv_d;
      write_en       <= we_d;
      sink_terminate <= term_d;
      len_err        <= len_d;
      proto_err      <= proto_d;
`ifdef TT_RX_TIMESTAMP_EN
      ts_hi_q        <= ts_hi_d;
      ts_lo_q        <= ts_lo_d;
      lat_q          <= lat_d;
      latv_q         <= latv_d;
`endif
    end
  end

endmodule

// File: tb/tb_tt_flit_receiver.sv
// Directed, table-driven bench for tt_flit_receiver; adapts the flit stream to TT_RX_TIMESTAMP_EN.
module tb_tt_flit_receiver;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_ILL  = 2'b11;
`ifdef TT_RX_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [33:0] flit_sink = '0;
  logic        valid_sink = 1'b0;
  logic        ready_sink;
  logic        core_stall = 1'b0;
  logic [63:0] GTB = '0;
  logic        portid_valid;
  logic [7:0]  sink_portid;
  logic        write_en;
  logic [31:0] sink_dataout;
  logic        sink_terminate;
  logic [31:0] latency;
  logic        latency_valid;
  logic        len_err;
  logic        proto_err;

  tt_flit_receiver dut (
    .clk(clk), .reset_n(reset_n), .flit_sink(flit_sink), .valid_sink(valid_sink),
    .ready_sink(ready_sink), .core_stall(core_stall), .GTB(GTB),
    .portid_valid(portid_valid), .sink_portid(sink_portid), .write_en(write_en),
    .sink_dataout(sink_dataout), .sink_terminate(sink_terminate), .latency(latency),
    .latency_valid(latency_valid), .len_err(len_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ftype;
    logic [31:0] fdata;
    logic        valid;
    logic        stall;
    logic [31:0] gtb;
    logic        exp_ready;
    logic        exp_pv;
    logic [7:0]  exp_portid;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_term;
    logic [31:0] exp_lat;
    logic        exp_latv;
    logic        exp_len;
    logic        exp_proto;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  hold_portid = 8'd0;
  logic [31:0] hold_data = 32'd0;
  logic [31:0] hold_lat = 32'd0;
  int          checks = 0;
  int          failures = 0;

  function automatic void check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endfunction

  // registered outputs that are not pulses keep their last value between updates
  function automatic void add(logic [1:0] t, logic [31:0] d, logic v, logic s, logic [31:0] g,
                              logic pv, logic we, logic term, logic len, logic proto,
                              logic [31:0] lat);
    vec_t x;
    if (pv) hold_portid = d[7:0];
    if (we) hold_data = d;
    if (term && TS_EN) hold_lat = lat;
    x.ftype = t;  x.fdata = d;  x.valid = v;  x.stall = s;  x.gtb = g;
    x.exp_ready = ~s;
    x.exp_pv = pv;
    x.exp_portid = hold_portid;
    x.exp_we = we;
    x.exp_data = hold_data;
    x.exp_term = term;
    x.exp_lat = hold_lat;
    x.exp_latv = term && TS_EN;
    x.exp_len = len;
    x.exp_proto = proto;
    vecs.push_back(x);
  endfunction

  function automatic void hdr(logic [7:0] port, logic [9:0] len, logic proto);
    add(T_HEAD, {8'hA5, 6'd0, len, port}, 1, 0, 0, 1, 0, 0, 0, proto, 0);
  endfunction

  function automatic void ts(logic [31:0] hi, logic [31:0] lo);
    if (TS_EN) begin
      add(T_BODY, hi, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(T_BODY, lo, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endfunction

  function automatic void body(logic [31:0] d);
    add(T_BODY, d, 1, 0, 0, 0, 1, 0, 0, 0, 0);
  endfunction

  function automatic void tail(logic [31:0] d, logic [31:0] g, logic [31:0] lat, logic len);
    add(T_TAIL, d, 1, 0, g, 0, 1, 1, len, 0, lat);
  endfunction

  function automatic void err(logic [1:0] t, logic [31:0] d);
    add(t, d, 1, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  function automatic void stalled(logic [31:0] d);
    add(T_BODY, d, 1, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void idle();
    add(T_BODY, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic applyStimulus(input vec_t x, input int idx);
    flit_sink  = {x.ftype, x.fdata};
    valid_sink = x.valid;
    core_stall = x.stall;
    GTB        = {32'hABCD0123, x.gtb};
    #2;
    check("ready_sink", idx, 32'(ready_sink), 32'(x.exp_ready));
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t x, input int idx);
    check("portid_valid", idx, 32'(portid_valid), 32'(x.exp_pv));
    check("sink_portid", idx, 32'(sink_portid), 32'(x.exp_portid));
    check("write_en", idx, 32'(write_en), 32'(x.exp_we));
    check("sink_dataout", idx, sink_dataout, x.exp_data);
    check("sink_terminate", idx, 32'(sink_terminate), 32'(x.exp_term));
    check("latency", idx, latency, x.exp_lat);
    check("latency_valid", idx, 32'(latency_valid), 32'(x.exp_latv));
    check("len_err", idx, 32'(len_err), 32'(x.exp_len));
    check("proto_err", idx, 32'(proto_err), 32'(x.exp_proto));
  endtask

  task automatic runVectors(input int base);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], base + i);
      checkOutput(vecs[i], base + i);
    end
    vecs.delete();
  endtask

  task automatic checkReset(input int tag);
    vec_t z;
    z.exp_pv = 0;  z.exp_portid = 0;  z.exp_we = 0;  z.exp_data = 0;  z.exp_term = 0;
    z.exp_lat = 0;  z.exp_latv = 0;  z.exp_len = 0;  z.exp_proto = 0;
    check("ready_in_reset", tag, 32'(ready_sink), 32'd0);
    checkOutput(z, tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    #1 reset_n = 1'b0;
    #2 checkReset(9000);
    repeat (2) @(posedge clk);
    #1 checkReset(9001);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // nominal packet
    hdr(8'h05, 10'd3, 0);  ts(32'h0, 32'h100);
    body(32'hA1);  body(32'hA2);  tail(32'hA3, 32'h140, 32'h40, 0);  idle();
    // latency wrap-around
    hdr(8'h07, 10'd1, 0);  ts(32'h1, 32'hFFFF_FFF0);  tail(32'hB1, 32'h10, 32'h20, 0);
    // length mismatch: msglen 4, three payload flits
    hdr(8'h09, 10'd4, 0);  ts(32'h0, 32'h50);
    body(32'hC1);  body(32'hC2);  tail(32'hC3, 32'h60, 32'h10, 1);
    // non-header flits in IDLE
    err(T_BODY, 32'hDEAD);  err(T_TAIL, 32'hBEEF);  err(T_ILL, 32'h1234);
    // header during payload aborts and restarts
    hdr(8'h11, 10'd2, 0);  ts(32'h0, 32'h0);  body(32'hE1);
    hdr(8'h22, 10'd1, 1);  ts(32'h0, 32'h5);  tail(32'hE2, 32'h8, 32'h3, 0);
    // backpressure mid-payload
    hdr(8'h33, 10'd3, 0);  ts(32'h0, 32'h1000);  body(32'hF1);
    for (int k = 0; k < 5; k++) stalled(32'hF2);
    body(32'hF2);  tail(32'hF3, 32'h1234, 32'h234, 0);
    // msglen 0 is always a length error
    hdr(8'h01, 10'd0, 0);  ts(32'h0, 32'h0);  tail(32'h77, 32'h9, 32'h9, 1);
    // tail inside the timestamp phase
    if (TS_EN) begin
      hdr(8'h02, 10'd1, 0);  err(T_TAIL, 32'h5);  err(T_BODY, 32'h6);
    end
    // illegal type in payload returns to IDLE
    hdr(8'h03, 10'd2, 0);  ts(32'h0, 32'h0);  body(32'h99);
    err(T_ILL, 32'h98);  err(T_BODY, 32'h97);  idle();
    runVectors(0);

    // reset asserted mid-packet
    hdr(8'h04, 10'd3, 0);  ts(32'h0, 32'h0);  body(32'h44);
    runVectors(500);
    valid_sink = 1'b0;
    reset_n = 1'b0;
    #1 checkReset(9002);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    hold_portid = 8'd0;  hold_data = 32'd0;  hold_lat = 32'd0;
    err(T_BODY, 32'h45);  err(T_TAIL, 32'h46);  idle();
    hdr(8'h06, 10'd1, 0);  ts(32'h0, 32'h10);  tail(32'h66, 32'h30, 32'h20, 0);  idle();
    runVectors(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
